matrix_location_sequencer: RTL and testbench

MATRIX_LOCATION_SEQUENCER -- requirements
Module: matrix_location_sequencer

---
 rtl/matrix_location_sequencer.sv | 114 +++++++++++
 tb/tb_matrix_location_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_location_sequencer.sv
// Sweeps (layer, row) locations in row-major order over latched counts,
// handing one location per accepted beat to a downstream spreader.
module matrix_location_sequencer #(
  parameter int unsigned layer_index_size = 32,
  parameter int unsigned row_index_size   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [layer_index_size-1:0] layer_count,
  input  logic [row_index_size-1:0]   row_count,
  input  logic                        ready,
  output logic [layer_index_size-1:0] read_layer_index,
  output logic [row_index_size-1:0]   read_row_index,
  output logic                        valid,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned LW = layer_index_size;
  localparam int unsigned RW = row_index_size;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_layer;
  logic [RW-1:0]   r_row;
  logic [LW-1:0]   r_layer_last;
  logic [RW-1:0]   r_row_last;
  logic [LW-1:0]   w_layer_nxt;
  logic [RW-1:0]   w_row_nxt;
  logic            w_load;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;

  // Next state and next location; counts are stored as count-1 so the
  // all-ones maximum compares without overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_row_nxt   = r_row;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!abort && start) begin
          if ((layer_count != '0) && (row_count != '0)) begin
            w_load      = 1'b1;
            w_layer_nxt = '0;
            w_row_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (ready) begin
          if (r_row != r_row_last) begin
            w_row_nxt = r_row + RW'(1);
          end else if (r_layer != r_layer_last) begin
            w_row_nxt   = '0;
            w_layer_nxt = r_layer + LW'(1);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        if (abort) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, location and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_row        <= '0;
      r_layer_last <= '0;
      r_row_last   <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_row   <= w_row_nxt;
      if (w_load) begin
        r_layer_last <= layer_count - LW'(1);
        r_row_last   <= row_count - RW'(1);
      end
      r_valid <= (w_state_nxt == S_RUN);
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign read_layer_index = r_layer;
  assign read_row_index   = r_row;
  assign valid            = r_valid;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_matrix_location_sequencer.sv
// Directed bench: expected locations queued at stimulus time, popped by a
// beat monitor; status outputs checked with immediate assertions.
module tb_matrix_location_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, ready;
  logic [31:0] a_lc, a_rc, a_layer, a_row;
  logic        a_valid, a_busy, a_done;
  logic        b_start, b_abort, b_ready;
  logic [1:0]  b_lc, b_rc, b_layer, b_row;
  logic        b_valid, b_busy, b_done;

  int n_vec = 0;
  int n_err = 0;
  int a_done_cnt = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  always #5 clk = ~clk;

  matrix_location_sequencer u_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .layer_count(a_lc), .row_count(a_rc), .ready(ready),
    .read_layer_index(a_layer), .read_row_index(a_row),
    .valid(a_valid), .busy(a_busy), .done(a_done)
  );

  matrix_location_sequencer #(.layer_index_size(2), .row_index_size(2)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .layer_count(b_lc), .row_count(b_rc), .ready(b_ready),
    .read_layer_index(b_layer), .read_row_index(b_row),
    .valid(b_valid), .busy(b_busy), .done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int nl, input int nr);
    for (int l = 0; l < nl; l++)
      for (int r = 0; r < nr; r++)
        qa.push_back({32'(l), 32'(r)});
  endtask

  // Beat monitor: compares each transferred location with the queue head.
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (a_done === 1'b1) a_done_cnt++;
      if (a_valid === 1'b1 && ready === 1'b1) begin
        if (qa.size() == 0) chk("a_beat_extra", {a_layer, a_row}, 64'hDEAD);
        else begin
          e = qa.pop_front();
          chk("a_beat", {a_layer, a_row}, e);
        end
      end
      if (b_valid === 1'b1 && b_ready === 1'b1) begin
        if (qb.size() == 0) chk("b_beat_extra", 64'({b_layer, b_row}), 64'hDEAD);
        else begin
          e = qb.pop_front();
          chk("b_beat", 64'({b_layer, b_row}), e);
        end
      end
    end
  endtask

  task automatic wait_done_a(input int lim);
    int k = 0;
    while (a_done !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    chk("a_done_seen", 64'(a_done), 64'd1);
  endtask

  task automatic start_a(input logic [31:0] lc, input logic [31:0] rc);
    a_lc  = lc;
    a_rc  = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
    a_lc = '0; a_rc = '0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1; b_lc = '0; b_rc = '0;
    fork monitor(); join_none
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(a_valid), 0);
    chk("rst_busy",  64'(a_busy), 0);
    chk("rst_done",  64'(a_done), 0);
    chk("rst_loc",   {a_layer, a_row}, 0);

    // Basic 2x3 sweep
    push_a(2, 3);
    start_a(2, 3);
    chk("basic_first_valid", 64'(a_valid), 1);
    chk("basic_first_loc", {a_layer, a_row}, 0);
    chk("basic_busy", 64'(a_busy), 1);
    wait_done_a(20);
    chk("basic_done_valid", 64'(a_valid), 0);
    chk("basic_done_busy", 64'(a_busy), 1);
    tick();
    chk("basic_done_pulse", 64'(a_done), 0);
    chk("basic_idle_busy", 64'(a_busy), 0);
    chk("basic_q_empty", 64'(qa.size()), 0);

    // Backpressure at (0,1)
    push_a(2, 3);
    start_a(2, 3);
    tick();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_loc", {a_layer, a_row}, {32'd0, 32'd1});
      chk("bp_hold_valid", 64'(a_valid), 1);
    end
    ready = 1'b1;
    wait_done_a(20);
    tick();
    chk("bp_q_empty", 64'(qa.size()), 0);

    // Zero counts: straight to DONE, no valid
    start_a(3, 0);
    chk("zero_done", 64'(a_done), 1);
    chk("zero_valid", 64'(a_valid), 0);
    tick();
    chk("zero_done_clear", 64'(a_done), 0);
    chk("zero_busy_clear", 64'(a_busy), 0);
    start_a(0, 5);
    chk("zero_l_done", 64'(a_done), 1);
    tick();

    // Mid-sweep start ignored, abort at (1,0)
    push_a(1, 3);
    qa.push_back({32'd1, 32'd0});
    start_a(2, 3);
    a_lc = 1; a_rc = 1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("abort_at_loc", {a_layer, a_row}, {32'd1, 32'd0});
    dc = a_done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(a_valid), 0);
    chk("abort_busy", 64'(a_busy), 0);
    tick(); tick();
    chk("abort_no_done", 64'(a_done_cnt), 64'(dc));
    chk("abort_q_empty", 64'(qa.size()), 0);

    // Abort beats start in IDLE
    a_lc = 2; a_rc = 2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 64'(a_busy), 0);
    chk("idle_abort_valid", 64'(a_valid), 0);

    // Reset at (0,2), then a 1x1 sweep
    push_a(1, 3);
    start_a(2, 3);
    tick(); tick();
    chk("rst_mid_loc", {a_layer, a_row}, {32'd0, 32'd2});
    dc = a_done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_out", {28'd0, a_valid, a_busy, a_done, 1'b0, a_layer ^ a_row}, 0);
    chk("rst_mid_loc0", {a_layer, a_row}, 0);
    tick();
    chk("rst_mid_no_done", 64'(a_done_cnt), 64'(dc));
    push_a(1, 1);
    start_a(1, 1);
    chk("one_valid", 64'(a_valid), 1);
    tick();
    chk("one_done", 64'(a_done), 1);
    tick();
    chk("one_done_clear", 64'(a_done), 0);
    chk("one_q_empty", 64'(qa.size()), 0);

    // Narrow instance: 3x3 with 2-bit indices
    for (int l = 0; l < 3; l++)
      for (int r = 0; r < 3; r++)
        qb.push_back(64'({2'(l), 2'(r)}));
    b_lc = 2'd3; b_rc = 2'd3; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    dc = 0;
    while (b_done !== 1'b1 && dc < 20) begin
      tick();
      dc++;
    end
    chk("b_done_seen", 64'(b_done), 1);
    chk("b_last_loc", 64'({b_layer, b_row}), 64'({2'd2, 2'd2}));
    chk("b_beats", 64'(dc), 9);
    tick();
    chk("b_q_empty", 64'(qb.size()), 0);
    chk("b_idle", 64'(b_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
